launch_sequencer: RTL and testbench

- Host-side initiator for the processor's req/done handshake: stages input bytes into data memory, holds the core in reset while loading, starts the core with a one-cycle req pulse, waits for done (with timeout), then streams the result bytes back out.
- Sits beside the processor core inside the system wrapper; mem_own steers the shared data-memory port between the sequencer and the core.

---
 rtl/launch_pkg.sv | 32 +++
 rtl/launch_timer.sv | 59 +++++
 rtl/launch_sequencer.sv | 168 ++++++++++++++++
 tb/tb_launch_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/launch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : launch_pkg
// Description : Shared constants for the launch sequencer: default widths and
//               the FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package launch_pkg;

    // Default configuration values
    localparam int DEF_A_W       = 8;
    localparam int DEF_D_W       = 8;
    localparam int DEF_LOAD_BASE = 0;
    localparam int DEF_LOAD_LEN  = 64;
    localparam int DEF_RES_BASE  = 64;
    localparam int DEF_RES_LEN   = 8;
    localparam int DEF_TIMEOUT   = 4096;
    localparam int DEF_TO_W      = 16;

    // Sequencer state encoding
    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_LOAD    = 3'd1;
    localparam state_t S_RELEASE = 3'd2;
    localparam state_t S_KICK    = 3'd3;
    localparam state_t S_WAIT    = 3'd4;
    localparam state_t S_DRAIN   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/launch_timer.sv
`default_nettype none
// ============================================================================
// Module      : launch_timer
// Description : WAIT-state timeout counter plus optional req-to-done cycle
//               counter. Optional feature macro: LAUNCH_CYCLE_COUNT_EN
//               (undefined: cycles is tied to zero and no counter exists).
// Revision    : 1.0 - initial release
// ============================================================================
module launch_timer #(
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            count,
    output logic            expired,
    output logic [TO_W-1:0] cycles
);

    localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] timer_q;

    // Timeout counter: cleared on KICK, advances once per WAIT cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else if (clear) begin
            timer_q <= '0;
        end else if (count) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    // A TIMEOUT of zero disables expiry entirely
    assign expired = (TIMEOUT != 0) && (timer_q == TIMER_LAST);

`ifdef LAUNCH_CYCLE_COUNT_EN
    logic [TO_W-1:0] cycles_q;

    // Saturating cycle counter; holds its value outside WAIT until next KICK
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles_q <= '0;
        end else if (clear) begin
            cycles_q <= '0;
        end else if (count && (cycles_q != '1)) begin
            cycles_q <= cycles_q + 1'b1;
        end
    end

    assign cycles = cycles_q;
`else
    assign cycles = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/launch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : launch_sequencer
// Description : Host-side initiator for the core req/done handshake. Loads
//               input bytes into data memory with the core held in reset,
//               releases and kicks the core, waits for done (with timeout),
//               then streams result bytes back out.
//               Optional feature macro: LAUNCH_CYCLE_COUNT_EN (req-to-done
//               cycle counter on the cycles output).
// Revision    : 1.0 - initial release
// ============================================================================
module launch_sequencer
    import launch_pkg::*;
#(
    parameter int A_W       = DEF_A_W,
    parameter int D_W       = DEF_D_W,
    parameter int LOAD_BASE = DEF_LOAD_BASE,
    parameter int LOAD_LEN  = DEF_LOAD_LEN,
    parameter int RES_BASE  = DEF_RES_BASE,
    parameter int RES_LEN   = DEF_RES_LEN,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int TO_W      = DEF_TO_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            err,
    input  logic            in_valid,
    input  logic [D_W-1:0]  in_data,
    output logic            in_ready,
    output logic            cpu_reset,
    output logic            req,
    input  logic            done,
    output logic            mem_own,
    output logic            mem_wr_en,
    output logic [A_W-1:0]  mem_addr,
    output logic [D_W-1:0]  mem_wr_data,
    input  logic [D_W-1:0]  mem_rd_data,
    output logic            out_valid,
    output logic [D_W-1:0]  out_data,
    input  logic            out_ready,
    output logic [TO_W-1:0] cycles
);

    // Index shares the counter width; it must cover both LOAD_LEN and RES_LEN
    localparam int              IDX_W     = TO_W;
    localparam logic [IDX_W-1:0] LOAD_LAST = IDX_W'(LOAD_LEN - 1);
    localparam logic [IDX_W-1:0] RES_LAST  = IDX_W'(RES_LEN - 1);
    localparam logic [A_W-1:0]   LOAD_A    = A_W'(LOAD_BASE);
    localparam logic [A_W-1:0]   RES_A     = A_W'(RES_BASE);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             err_q, err_d;
    logic             expired;

    launch_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == S_KICK),
        .count   (state_q == S_WAIT),
        .expired (expired),
        .cycles  (cycles)
    );

    // State, index and sticky error registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            index_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; done only matters in WAIT and wins over expiry
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    index_d = '0;
                    state_d = (LOAD_LEN == 0) ? S_RELEASE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    index_d = index_q + 1'b1;
                    if (index_q == LOAD_LAST) begin
                        state_d = S_RELEASE;
                    end
                end
            end
            S_RELEASE: state_d = S_KICK;
            S_KICK:    state_d = S_WAIT;
            S_WAIT: begin
                if (done) begin
                    index_d = '0;
                    state_d = (RES_LEN == 0) ? S_IDLE : S_DRAIN;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    index_d = index_q + 1'b1;
                    if (index_q == RES_LAST) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; the core runs only in RELEASE, KICK and WAIT
    always_comb begin
        cpu_reset   = 1'b1;
        req         = 1'b0;
        in_ready    = 1'b0;
        mem_own     = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        out_valid   = 1'b0;
        out_data    = '0;
        case (state_q)
            S_LOAD: begin
                mem_own  = 1'b1;
                in_ready = 1'b1;
                mem_addr = LOAD_A + index_q[A_W-1:0];
                if (in_valid) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_data = in_data;
                end
            end
            S_RELEASE: cpu_reset = 1'b0;
            S_KICK: begin
                cpu_reset = 1'b0;
                req       = 1'b1;
            end
            S_WAIT:    cpu_reset = 1'b0;
            S_DRAIN: begin
                mem_own   = 1'b1;
                mem_addr  = RES_A + index_q[A_W-1:0];
                out_valid = 1'b1;
                out_data  = mem_rd_data;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_launch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_launch_sequencer
// Description : Self-checking bench for launch_sequencer. Instance u_dut runs
//               LOAD_LEN=4/RES_LEN=2/TIMEOUT=20; instance u_dut0 runs with
//               zero-length load/drain and no timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_launch_sequencer;

`ifdef LAUNCH_CYCLE_COUNT_EN
    localparam int EXP_CYC = 37;
`else
    localparam int EXP_CYC = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   errors = 0;
    int   checks = 0;

    // Main instance
    logic        start, in_valid, done, out_ready;
    logic [7:0]  in_data;
    logic        busy, err, in_ready, cpu_reset, req, mem_own, mem_wr_en, out_valid;
    logic [7:0]  mem_addr, mem_wr_data, mem_rd_data, out_data;
    logic [15:0] cycles;
    logic [7:0]  seed;

    // Zero-length instance
    logic        start2, done2;
    logic        busy2, err2, in_ready2, cpu_reset2, req2, mem_own2, mem_wr_en2, out_valid2;
    logic [7:0]  mem_addr2, mem_wr_data2, out_data2;
    logic [15:0] cycles2;

    // Scoreboards: {addr, data} pairs
    logic [15:0] wr_q[$];
    logic [15:0] rd_q[$];

    // Result-memory contents as seen through the read port
    function automatic logic [7:0] rd_pat(input logic [7:0] a, input logic [7:0] s);
        return (a * 8'd7) ^ s;
    endfunction

    assign mem_rd_data = rd_pat(mem_addr, seed);

    launch_sequencer #(
        .A_W(8), .D_W(8), .LOAD_BASE(0), .LOAD_LEN(4),
        .RES_BASE(64), .RES_LEN(2), .TIMEOUT(20), .TO_W(16)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .err(err),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cpu_reset(cpu_reset), .req(req), .done(done), .mem_own(mem_own),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .cycles(cycles)
    );

    launch_sequencer #(
        .A_W(8), .D_W(8), .LOAD_BASE(0), .LOAD_LEN(0),
        .RES_BASE(64), .RES_LEN(0), .TIMEOUT(0), .TO_W(16)
    ) u_dut0 (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .err(err2),
        .in_valid(1'b0), .in_data(8'h00), .in_ready(in_ready2),
        .cpu_reset(cpu_reset2), .req(req2), .done(done2), .mem_own(mem_own2),
        .mem_wr_en(mem_wr_en2), .mem_addr(mem_addr2), .mem_wr_data(mem_wr_data2),
        .mem_rd_data(8'h00), .out_valid(out_valid2), .out_data(out_data2),
        .out_ready(1'b1), .cycles(cycles2)
    );

    // Stimulus: start a job and stream LOAD_LEN bytes back to back (unchecked)
    task automatic run_load();
        @(negedge clk); start = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'(i + 8'h80); #1;
        end
    endtask

    // Stimulus: idle inputs until req is seen (bounded); returns in KICK cycle
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk); start = 1'b0; in_valid = 1'b0; done = 1'b0; #1;
            if (req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; in_valid = 0; in_data = 0; done = 0; out_ready = 0;
        start2 = 0; done2 = 0; seed = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, err, in_ready, cpu_reset, req, mem_own, mem_wr_en, out_valid} !== 8'b0001_0000)
            begin errors++; $display("FAIL reset_ctl: got %b want 00010000",
                {busy, err, in_ready, cpu_reset, req, mem_own, mem_wr_en, out_valid}); end
        checks++;
        if (mem_addr !== 8'h00 || cycles !== 16'h0)
            begin errors++; $display("FAIL reset_addr_cyc: got addr=%h cycles=%h want 0/0", mem_addr, cycles); end
        checks++;
        if (busy2 !== 1'b0 || cpu_reset2 !== 1'b1 || req2 !== 1'b0)
            begin errors++; $display("FAIL reset_dut0: got busy=%b cpu_reset=%b req=%b want 0/1/0", busy2, cpu_reset2, req2); end
        @(negedge clk); reset = 1'b0; #1;
        checks++;
        if (busy !== 1'b0 || cpu_reset !== 1'b1)
            begin errors++; $display("FAIL post_reset_idle: got busy=%b cpu_reset=%b want 0/1", busy, cpu_reset); end
    endtask

    task automatic test_basic();
        logic [7:0]  b [4];
        logic [15:0] exp;
        bit          bad;
        int          n;
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
        seed = 8'h3C;
        @(negedge clk); start = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = b[i];
            wr_q.push_back({8'(i), b[i]});
            #1;
            checks++;
            if (in_ready !== 1'b1 || cpu_reset !== 1'b1 || mem_own !== 1'b1)
                begin errors++; $display("FAIL load_ctl[%0d]: got rdy=%b cpu_rst=%b own=%b want 1/1/1", i, in_ready, cpu_reset, mem_own); end
            exp = wr_q.pop_front();
            checks++;
            if (mem_wr_en !== 1'b1 || {mem_addr, mem_wr_data} !== exp)
                begin errors++; $display("FAIL load_wr[%0d]: got en=%b addr/data=%h want 1/%h", i, mem_wr_en, {mem_addr, mem_wr_data}, exp); end
        end
        @(negedge clk); in_valid = 1'b0; #1;
        checks++;
        if (cpu_reset !== 1'b0 || mem_own !== 1'b0 || req !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL release: got cpu_rst=%b own=%b req=%b busy=%b want 0/0/0/1", cpu_reset, mem_own, req, busy); end
        @(negedge clk); #1;
        checks++;
        if (req !== 1'b1)
            begin errors++; $display("FAIL kick_req: got %b want 1", req); end
        bad = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk); done = (j == 10);
            if (j == 10) begin
                rd_q.push_back({8'd64, rd_pat(8'd64, seed)});
                rd_q.push_back({8'd65, rd_pat(8'd65, seed)});
            end
            #1;
            if (req !== 1'b0 || out_valid !== 1'b0 || cpu_reset !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL wait_outputs: got req/out_valid/cpu_reset active in WAIT want 0/0/0"); end
        n = 0;
        for (int t = 0; t < 10 && n < 2; t++) begin
            @(negedge clk); done = 1'b0; out_ready = 1'b1; #1;
            if (out_valid === 1'b1) begin
                exp = rd_q.pop_front();
                checks++;
                if ({mem_addr, out_data} !== exp || cpu_reset !== 1'b1 || mem_own !== 1'b1)
                    begin errors++; $display("FAIL drain[%0d]: got addr/data=%h cpu_rst=%b own=%b want %h/1/1", n, {mem_addr, out_data}, cpu_reset, mem_own, exp); end
                n++;
            end
        end
        checks++;
        if (n != 2) begin errors++; $display("FAIL drain_count: got %0d want 2", n); rd_q.delete(); end
        @(negedge clk); out_ready = 1'b0; #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL basic_end: got busy=%b out_valid=%b want 0/0", busy, out_valid); end
    endtask

    task automatic test_gappy();
        logic [15:0] exp;
        logic [7:0]  d;
        int          sent, c;
        bit          ok;
        seed = 8'h5A;
        @(negedge clk); start = 1'b1; #1;
        sent = 0; c = 0;
        while (sent < 4 && c < 40) begin
            @(negedge clk); start = 1'b0; c++;
            in_valid = ((c % 3) == 0);
            d = 8'($urandom);
            in_data = d;
            if (in_valid) begin wr_q.push_back({8'(sent), d}); sent++; end
            #1;
            if (in_valid) begin
                exp = wr_q.pop_front();
                checks++;
                if (mem_wr_en !== 1'b1 || {mem_addr, mem_wr_data} !== exp)
                    begin errors++; $display("FAIL gappy_wr: got en=%b addr/data=%h want 1/%h", mem_wr_en, {mem_addr, mem_wr_data}, exp); end
            end else if (mem_wr_en !== 1'b0 || in_ready !== 1'b1) begin
                checks++; errors++;
                $display("FAIL gappy_idle: got wr_en=%b in_ready=%b want 0/1", mem_wr_en, in_ready);
            end
        end
        wait_req(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL gappy_req: got no req want req"); end
        repeat (3) begin @(negedge clk); #1; end
        @(negedge clk); done = 1'b1;
        rd_q.push_back({8'd64, rd_pat(8'd64, seed)});
        rd_q.push_back({8'd65, rd_pat(8'd65, seed)});
        #1;
        @(negedge clk); done = 1'b0; out_ready = 1'b1; #1;
        exp = rd_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {mem_addr, out_data} !== exp)
            begin errors++; $display("FAIL gappy_rd0: got v=%b addr/data=%h want 1/%h", out_valid, {mem_addr, out_data}, exp); end
        for (int s = 0; s < 5; s++) begin
            @(negedge clk); out_ready = 1'b0; #1;
            checks++;
            if (out_valid !== 1'b1 || {mem_addr, out_data} !== rd_q[0])
                begin errors++; $display("FAIL stall[%0d]: got v=%b addr/data=%h want 1/%h", s, out_valid, {mem_addr, out_data}, rd_q[0]); end
        end
        @(negedge clk); out_ready = 1'b1; #1;
        exp = rd_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {mem_addr, out_data} !== exp)
            begin errors++; $display("FAIL gappy_rd1: got v=%b addr/data=%h want 1/%h", out_valid, {mem_addr, out_data}, exp); end
        @(negedge clk); out_ready = 1'b0; #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL gappy_end: got busy=%b want 0", busy); end
    endtask

    task automatic test_timeout();
        logic [15:0] exp;
        bit          ok;
        seed = 8'hA7;
        run_load();
        wait_req(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL to_req: got no req want req"); end
        for (int j = 1; j <= 21; j++) begin
            @(negedge clk); #1;
            if (j == 20) begin
                checks++;
                if (err !== 1'b0 || busy !== 1'b1)
                    begin errors++; $display("FAIL to_pre: got err=%b busy=%b want 0/1", err, busy); end
            end
            if (j == 21) begin
                checks++;
                if (err !== 1'b1 || busy !== 1'b0 || cpu_reset !== 1'b1)
                    begin errors++; $display("FAIL to_hit: got err=%b busy=%b cpu_rst=%b want 1/0/1", err, busy, cpu_reset); end
            end
        end
        // Restart: err clears, done pulsed in LOAD is ignored
        @(negedge clk); start = 1'b1; #1;
        @(negedge clk); start = 1'b0; done = 1'b1; #1;
        checks++;
        if (err !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL err_clear: got err=%b in_ready=%b want 0/1", err, in_ready); end
        @(negedge clk); done = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || req !== 1'b0)
            begin errors++; $display("FAIL done_in_load: got rdy=%b ov=%b req=%b want 1/0/0", in_ready, out_valid, req); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = 8'(i); #1;
        end
        wait_req(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL term_req: got no req want req"); end
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk); done = (j == 20);
            if (j == 20) begin
                rd_q.push_back({8'd64, rd_pat(8'd64, seed)});
                rd_q.push_back({8'd65, rd_pat(8'd65, seed)});
            end
            #1;
        end
        @(negedge clk); done = 1'b0; out_ready = 1'b1; #1;
        exp = rd_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || err !== 1'b0 || {mem_addr, out_data} !== exp)
            begin errors++; $display("FAIL term_done: got v=%b err=%b addr/data=%h want 1/0/%h", out_valid, err, {mem_addr, out_data}, exp); end
        @(negedge clk); #1;
        exp = rd_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {mem_addr, out_data} !== exp)
            begin errors++; $display("FAIL term_rd1: got v=%b addr/data=%h want 1/%h", out_valid, {mem_addr, out_data}, exp); end
        @(negedge clk); out_ready = 1'b0; #1;
        checks++;
        if (busy !== 1'b0 || err !== 1'b0)
            begin errors++; $display("FAIL term_end: got busy=%b err=%b want 0/0", busy, err); end
    endtask

    task automatic test_reset_mid_drain();
        bit ok;
        seed = 8'h19;
        run_load();
        wait_req(ok);
        @(negedge clk); done = 1'b1; #1;
        @(negedge clk); done = 1'b0; out_ready = 1'b0; #1;
        checks++;
        if (!ok || out_valid !== 1'b1 || mem_addr !== 8'd64)
            begin errors++; $display("FAIL pre_abort: got req_ok=%b ov=%b addr=%h want 1/1/40", ok, out_valid, mem_addr); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, err, in_ready, cpu_reset, req, mem_own, mem_wr_en, out_valid} !== 8'b0001_0000 || mem_addr !== 8'h00)
            begin errors++; $display("FAIL async_abort: got ctl=%b addr=%h want 00010000/00",
                {busy, err, in_ready, cpu_reset, req, mem_own, mem_wr_en, out_valid}, mem_addr); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_zero_len();
        @(negedge clk); start2 = 1'b1; #1;
        @(negedge clk); start2 = 1'b0; #1;
        checks++;
        if (busy2 !== 1'b1 || cpu_reset2 !== 1'b0 || in_ready2 !== 1'b0 || req2 !== 1'b0)
            begin errors++; $display("FAIL zl_release: got busy=%b cpu_rst=%b rdy=%b req=%b want 1/0/0/0", busy2, cpu_reset2, in_ready2, req2); end
        @(negedge clk); #1;
        checks++;
        if (req2 !== 1'b1) begin errors++; $display("FAIL zl_req_c2: got %b want 1", req2); end
        for (int j = 1; j <= 37; j++) begin
            @(negedge clk); done2 = (j == 37); #1;
        end
        @(negedge clk); done2 = 1'b0; #1;
        checks++;
        if (busy2 !== 1'b0 || out_valid2 !== 1'b0 || err2 !== 1'b0)
            begin errors++; $display("FAIL zl_idle: got busy=%b ov=%b err=%b want 0/0/0", busy2, out_valid2, err2); end
        checks++;
        if (cycles2 !== 16'(EXP_CYC))
            begin errors++; $display("FAIL cycles: got %0d want %0d", cycles2, EXP_CYC); end
        repeat (3) begin @(negedge clk); #1; end
        checks++;
        if (cycles2 !== 16'(EXP_CYC) || cpu_reset2 !== 1'b1 || mem_wr_en2 !== 1'b0 || mem_own2 !== 1'b0)
            begin errors++; $display("FAIL cycles_hold: got cyc=%0d cpu_rst=%b wr=%b own=%b want %0d/1/0/0", cycles2, cpu_reset2, mem_wr_en2, mem_own2, EXP_CYC); end
        checks++;
        if (mem_addr2 !== 8'h00 || mem_wr_data2 !== 8'h00 || out_data2 !== 8'h00)
            begin errors++; $display("FAIL zl_mem_idle: got addr=%h wd=%h od=%h want 00/00/00", mem_addr2, mem_wr_data2, out_data2); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gappy();
        test_timeout();
        test_reset_mid_drain();
        test_zero_len();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
